// File: rtl/bcd_countdown_timer.sv
// Cascadable N-digit BCD down-counter with parallel load, start/pause control,
// optional auto-reload and a one-cycle terminal-count pulse.
module bcd_countdown_timer #(
   parameter int unsigned DIGITS = 2,
   parameter bit          WRAP   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  pause,
   output logic [4*DIGITS-1:0]   count,
   output logic                  running,
   output logic                  done,
   output logic                  invalid
);

   localparam int unsigned W = 4 * DIGITS;

   typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

   state_e         state;
   logic [W-1:0]   reload;

   function automatic logic is_bcd(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Borrow ripples through every digit in the same cycle.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] res;
      logic         borrow;
      res    = v;
      borrow = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               res[4*i +: 4] = 4'd9;
            end else begin
               res[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow        = 1'b0;
            end
         end
      end
      return res;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= StIdle;
         count   <= '0;
         reload  <= '0;
         running <= 1'b0;
         done    <= 1'b0;
         invalid <= 1'b0;
      end else begin
         done    <= 1'b0;
         invalid <= 1'b0;
         if (load) begin
            if (is_bcd(load_val)) begin
               count   <= load_val;
               reload  <= load_val;
               state   <= StIdle;
               running <= 1'b0;
            end else begin
               invalid <= 1'b1;
            end
         end else if (pause) begin
            if (state == StRun) begin
               state   <= StHold;
               running <= 1'b0;
            end
         end else if (start && state != StRun) begin
            // A tick arriving with start is not counted.
            if (state == StHold || count != '0) begin
               state   <= StRun;
               running <= 1'b1;
            end
         end else if (tick && state == StRun) begin
            if (count == '0) begin
               // Only reachable with WRAP=1: the tick after terminal count reloads.
               count <= reload;
            end else if (count == W'(1)) begin
               count <= '0;
               done  <= 1'b1;
               if (!WRAP) begin
                  state   <= StIdle;
                  running <= 1'b0;
               end
            end else begin
               count <= bcd_dec(count);
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench: a vector table for the 2-digit non-wrapping counter plus
// hand sequences for borrow ripple, auto-reload and asynchronous reset.
module tb_bcd_countdown_timer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
   logic [11:0] lv = '0;

   logic [7:0]  a_count, c_count;
   logic [11:0] b_count;
   logic        a_run, a_done, a_inv;
   logic        b_run, b_done, b_inv;
   logic        c_run, c_done, c_inv;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   bcd_countdown_timer #(.DIGITS(2), .WRAP(1'b0)) dut_a (
      .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(lv[7:0]),
      .start(start), .pause(pause), .count(a_count), .running(a_run),
      .done(a_done), .invalid(a_inv)
   );

   bcd_countdown_timer #(.DIGITS(3), .WRAP(1'b0)) dut_b (
      .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(lv),
      .start(start), .pause(pause), .count(b_count), .running(b_run),
      .done(b_done), .invalid(b_inv)
   );

   bcd_countdown_timer #(.DIGITS(2), .WRAP(1'b1)) dut_c (
      .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(lv[7:0]),
      .start(start), .pause(pause), .count(c_count), .running(c_run),
      .done(c_done), .invalid(c_inv)
   );

   typedef struct {
      logic       tk, ld, st, ps;
      logic [7:0] val;
      logic [7:0] cnt;
      logic       run, dn, inv;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   // Inputs change 1 time unit after the rising edge; outputs checked likewise.
   task automatic cyc(input logic t, input logic l, input logic s, input logic p,
                      input logic [11:0] v);
      tick = t; load = l; start = s; pause = p; lv = v;
      @(posedge clk);
      #1;
      tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
   endtask

   task automatic add(input logic t, input logic l, input logic s, input logic p,
                      input logic [7:0] v, input logic [7:0] c, input logic r,
                      input logic d, input logic i);
      vec_t x;
      x = '{tk: t, ld: l, st: s, ps: p, val: v, cnt: c, run: r, dn: d, inv: i};
      vecs.push_back(x);
   endtask

   initial begin
      // Basic countdown from 12 with tick held high throughout.
      add(0, 1, 0, 0, 8'h12, 8'h12, 0, 0, 0);
      add(0, 0, 1, 0, 8'h00, 8'h12, 1, 0, 0);
      add(1, 0, 0, 0, 8'h00, 8'h11, 1, 0, 0);
      add(1, 0, 0, 0, 8'h00, 8'h10, 1, 0, 0);
      add(1, 0, 0, 0, 8'h00, 8'h09, 1, 0, 0);
      for (int k = 8; k >= 1; k--) add(1, 0, 0, 0, 8'h00, 8'(k), 1, 0, 0);
      add(1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
      add(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
      add(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
      add(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
      // Rejected load leaves count and RUN state alone.
      add(0, 1, 0, 0, 8'h34, 8'h34, 0, 0, 0);
      add(0, 0, 1, 0, 8'h00, 8'h34, 1, 0, 0);
      add(0, 1, 0, 0, 8'h3A, 8'h34, 1, 0, 1);
      add(1, 0, 0, 0, 8'h00, 8'h33, 1, 0, 0);
      add(0, 1, 0, 0, 8'h05, 8'h05, 0, 0, 0);
      add(0, 1, 0, 0, 8'hA0, 8'h05, 0, 0, 1);
      // Pause and resume.
      add(0, 1, 0, 0, 8'h20, 8'h20, 0, 0, 0);
      add(0, 0, 1, 0, 8'h00, 8'h20, 1, 0, 0);
      add(1, 0, 0, 0, 8'h00, 8'h19, 1, 0, 0);
      add(1, 0, 0, 0, 8'h00, 8'h18, 1, 0, 0);
      add(1, 0, 0, 0, 8'h00, 8'h17, 1, 0, 0);
      add(1, 0, 0, 0, 8'h00, 8'h16, 1, 0, 0);
      add(1, 0, 0, 0, 8'h00, 8'h15, 1, 0, 0);
      add(0, 0, 0, 1, 8'h00, 8'h15, 0, 0, 0);
      add(1, 0, 0, 0, 8'h00, 8'h15, 0, 0, 0);
      add(1, 0, 0, 1, 8'h00, 8'h15, 0, 0, 0);
      add(1, 0, 0, 0, 8'h00, 8'h15, 0, 0, 0);
      add(1, 0, 1, 0, 8'h00, 8'h15, 1, 0, 0);
      add(1, 0, 0, 0, 8'h00, 8'h14, 1, 0, 0);
      add(0, 0, 1, 1, 8'h00, 8'h14, 0, 0, 0);
      add(0, 0, 1, 1, 8'h00, 8'h14, 0, 0, 0);
      add(0, 0, 1, 0, 8'h00, 8'h14, 1, 0, 0);
      add(1, 0, 0, 1, 8'h00, 8'h14, 0, 0, 0);
      add(0, 0, 1, 0, 8'h00, 8'h14, 1, 0, 0);
      add(1, 0, 0, 0, 8'h00, 8'h13, 1, 0, 0);
      // Load beats tick; load of zero never pulses done.
      add(1, 1, 0, 0, 8'h07, 8'h07, 0, 0, 0);
      add(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
      add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);

      // Asynchronous reset mid-cycle.
      #3 rst = 1'b1;
      #1;
      check("rst_count_async", {4'h0, a_count}, 12'h000);
      check("rst_flags_async", {9'h0, a_run, a_done, a_inv}, 12'h000);
      check("rst_b_count", b_count, 12'h000);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         cyc(vecs[i].tk, vecs[i].ld, vecs[i].st, vecs[i].ps, {4'h0, vecs[i].val});
         check($sformatf("v%0d_count", i), {4'h0, a_count}, {4'h0, vecs[i].cnt});
         check($sformatf("v%0d_running", i), {11'h0, a_run}, {11'h0, vecs[i].run});
         check($sformatf("v%0d_done", i), {11'h0, a_done}, {11'h0, vecs[i].dn});
         check($sformatf("v%0d_invalid", i), {11'h0, a_inv}, {11'h0, vecs[i].inv});
      end

      // Borrow ripple across three digits.
      cyc(0, 1, 0, 0, 12'h100);
      check("borrow_load", b_count, 12'h100);
      cyc(0, 0, 1, 0, 12'h000);
      check("borrow_running", {11'h0, b_run}, 12'h001);
      cyc(1, 0, 0, 0, 12'h000);
      check("borrow_099", b_count, 12'h099);
      cyc(1, 0, 0, 0, 12'h000);
      check("borrow_098", b_count, 12'h098);

      // Auto-reload.
      cyc(0, 1, 0, 0, 12'h003);
      cyc(0, 0, 1, 0, 12'h000);
      check("wrap_running_start", {11'h0, c_run}, 12'h001);
      begin
         logic [7:0] exp_c [6];
         logic       exp_d [6];
         exp_c = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01};
         exp_d = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
         for (int k = 0; k < 6; k++) begin
            cyc(1, 0, 0, 0, 12'h000);
            check($sformatf("wrap%0d_count", k), {4'h0, c_count}, {4'h0, exp_c[k]});
            check($sformatf("wrap%0d_done", k), {11'h0, c_done}, {11'h0, exp_d[k]});
            check($sformatf("wrap%0d_running", k), {11'h0, c_run}, 12'h001);
         end
      end

      // Reset mid-count at 07, then start is ignored at zero.
      cyc(0, 1, 0, 0, 12'h009);
      cyc(0, 0, 1, 0, 12'h000);
      cyc(1, 0, 0, 0, 12'h000);
      cyc(1, 0, 0, 0, 12'h000);
      check("midrst_pre", {4'h0, a_count}, 12'h007);
      #2 rst = 1'b1;
      #1;
      check("midrst_count", {4'h0, a_count}, 12'h000);
      check("midrst_running", {11'h0, a_run}, 12'h000);
      check("midrst_done", {11'h0, a_done}, 12'h000);
      @(posedge clk);
      #1 rst = 1'b0;
      cyc(0, 0, 1, 0, 12'h000);
      check("midrst_start_ignored", {11'h0, a_run}, 12'h000);
      cyc(1, 0, 0, 0, 12'h000);
      check("midrst_tick_count", {4'h0, a_count}, 12'h000);
      check("midrst_tick_done", {11'h0, a_done}, 12'h000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Cascadable N-digit BCD down-counter with parallel load, start/pause control and a terminal-count pulse. It is the counting-down counterpart of the free-running decade up-counter in the display path. It drives the same seven-segment digit outputs when the board runs in countdown-timer mode. Counting advances only on a single-cycle `tick` strobe from the shared prescaler, so `clk` remains the fast board clock.

## Interface
- `DIGITS`, default 2: number of BCD digits. `count` width is 4*DIGITS. Legal range is 1–8.
- `WRAP`, default 0: terminal-count behaviour.
  - 0: stop at zero and return to IDLE.
  - 1: auto-reload the last loaded value and keep running.
- `clk`, in, 1: system clock, rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `tick`, in, 1: count-enable strobe, one `clk` cycle wide.
- `load`, in, 1: parallel-load request.
- `load_val`, in, 4*DIGITS: BCD load value. Digit 0 is bits [3:0].
- `start`, in, 1: begin or resume counting.
- `pause`, in, 1: suspend counting.
- `count`, out, 4*DIGITS: current BCD value, registered.
- `running`, out, 1: high while the state is RUN.
- `done`, out, 1: one-cycle pulse when `count` reaches zero.
- `invalid`, out, 1: one-cycle pulse when a load is rejected.

## Operation
- Reset: `rst` is asynchronous and active-high, clocked by `clk`. While `rst` is high:
  - `count` = 0 and the state is IDLE.
  - `running`, `done` and `invalid` = 0.
  - The internal reload register = 0.
- States: IDLE, RUN, HOLD.
- Priority, highest first: `rst`, `load`, `pause`, `start`, `tick`.
- Load (accepted in any state):
  - Valid load (every digit of `load_val` ≤ 9): `count` and the reload register take `load_val`, and the state goes to IDLE.
  - Rejected load (any digit > 9): `count`, the reload register and the state are unchanged, and `invalid` pulses.
- IDLE:
  - `start` with `count` ≠ 0 goes to RUN.
  - `start` with `count` = 0 is ignored.
  - `tick` is ignored.
- RUN:
  - `pause` goes to HOLD.
  - On `tick`, `count` decrements in BCD. Digit 0 goes down by 1. A digit at 0 becomes 9 and borrows from the next digit; the borrow ripples through all digits in the same cycle.
  - `count` never holds a non-BCD digit.
- Terminal count (in RUN, `tick` while `count` = 1):
  - `count` becomes 0 and `done` pulses.
  - WRAP=0: the state goes to IDLE.
  - WRAP=1: the state stays RUN, and the next `tick` loads the reload value instead of decrementing.
- WRAP=1 with a reload value of 0 cannot occur: it is unreachable because `start` is ignored at 0.
- HOLD:
  - `start` goes to RUN.
  - `tick` and `pause` are ignored.
  - `count` holds.
- Simultaneous events:
  - `start` and `pause` together: `pause` wins. In RUN the block goes to HOLD; in HOLD or IDLE it stays.
  - `start` and `tick` together in IDLE or HOLD: the state goes to RUN and the tick is not counted.
  - `load` and `tick` together: the load wins and the tick is dropped.
  - `pause` and `tick` together in RUN: the block goes to HOLD and the tick is dropped.
- Reset mid-count: the block returns immediately to the reset values above. The loaded value is lost.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- Load to `count` valid: 1 cycle. `invalid` is asserted in that same cycle.
- `start` to `running` = 1: 1 cycle.
- `tick` to `count` update: 1 cycle. The first counted tick is the first one after the cycle in which `running` = 1.
- `done` is high for exactly the one cycle in which `count` first shows 0. It is never asserted on reset or on a load of 0.
- In WRAP=1, `running` stays high across the terminal count.
- In WRAP=0, `running` drops in the same cycle that `done` rises.
- A `tick` held high for several cycles counts once per cycle. The bench must exercise this.

## Test plan
- Reset and basic countdown (DIGITS=2, WRAP=0):
  - Stimulus: assert `rst` mid-cycle, then release, load 0x12, `start`, then 12 ticks.
  - Required: while `rst` is high, `count` = 0x00 and all flags are 0, asynchronously.
  - Required: `count` steps 12, 11, 10, 09, 08 … 01, 00.
  - Required: `done` is a single pulse with `count` = 00, then `running` = 0 and further ticks leave 00.
- Borrow ripple (DIGITS=3): load 0x100, `start`, 1 tick → `count` = 0x099. A second tick → 0x098.
- Invalid load:
  - Load 0x34, then load 0x3A.
  - Required: `invalid` pulses once, `count` stays 0x34, the state is unchanged.
  - A following load of 0x05 gives `count` 05 and `invalid` 0.
- Pause and resume:
  - Load 0x20, `start`, 5 ticks → 15. `pause`, 3 ticks → `count` still 15 and `running` 0.
  - `start` together with `tick` → `count` still 15 and `running` 1. The next tick gives 14.
  - `start` and `pause` in the same cycle while in RUN → HOLD.
- WRAP=1:
  - Load 0x03, `start`, 6 ticks → 02, 01, 00 (`done`), 03, 02, 01.
  - `running` stays 1 throughout and there is one `done` pulse per pass.
- Reset and zero edge cases:
  - Assert `rst` mid-count at 0x07 → `count` 0 and IDLE immediately. `start` after release is ignored because `count` = 0.
  - Load 0x00 → no `done` pulse.
